// File: rtl/ddr3_rdlvl_pkg.sv
// ddr3_rdlvl_pkg: shared types and constants for the DDR3 read-leveling lane aligner.
//   rdlvl_state_t : aligner FSM state encoding
//   NUM_SLIPS     : number of distinct bit positions in one 8-bit deserialized word
//   SLIP_CNT_W    : width of the per-attempt slip counter
package ddr3_rdlvl_pkg;

   localparam int unsigned NUM_SLIPS  = 8;
   localparam int unsigned SLIP_CNT_W = 3;
   localparam int unsigned LANE_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_SLIP   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_LOCKED = 3'd4,
      ST_FAIL   = 3'd5
   } rdlvl_state_t;

endpackage : ddr3_rdlvl_pkg

// File: rtl/ddr3_rdlvl_err_cnt.sv
// ddr3_rdlvl_err_cnt: saturating post-lock pattern-mismatch counter.
// Only built when DDR3_RDLVL_ERR_CNT_EN is defined.
// Ports:
//   i_clk  in  1  clock, rising edge
//   i_rst  in  1  synchronous active-high reset
//   i_clr  in  1  synchronous clear, wins over i_inc
//   i_inc  in  1  increment request (ignored once saturated)
//   o_cnt  out W  current count
`ifdef DDR3_RDLVL_ERR_CNT_EN
module ddr3_rdlvl_err_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count up, holding at all-ones.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule : ddr3_rdlvl_err_cnt
`endif

// File: rtl/ddr3_rdlvl_lane_align.sv
// ddr3_rdlvl_lane_align: receive-side read-leveling word aligner for one DDR3 DQ lane.
// Pulses the IOD bit-slip until the deserialized word matches TRAIN_PATTERN for
// MATCH_CNT consecutive words, then forwards aligned read data.
// Optional feature macro: DDR3_RDLVL_ERR_CNT_EN (post-lock mismatch counter).
// Ports:
//   FAB_CLK        in   1      fabric clock, rising edge
//   RX_SYNC_RST    in   1      synchronous active-high reset
//   TRAIN_START    in   1      begin/restart alignment (one-cycle pulse)
//   RX_DATA        in   8      deserialized lane word, bit0 = first beat
//   RD_VALID_IN    in   1      read gate aligned to RX_DATA
//   PATTERN_MON    in   1      controller is replaying TRAIN_PATTERN
//   RX_BIT_SLIP    out  1      one-cycle slip request to IOD
//   TRAIN_DONE     out  1      lane locked
//   TRAIN_FAIL     out  1      no alignment found
//   SLIP_COUNT     out  3      slips issued in current attempt
//   RD_DATA        out  8      aligned read data
//   RD_DATA_VALID  out  1      RD_DATA qualifier
//   ERR_COUNT      out  ERR_W  post-lock pattern mismatch count
module ddr3_rdlvl_lane_align
   import ddr3_rdlvl_pkg::*;
#(
   parameter logic [7:0]  TRAIN_PATTERN = 8'hB4,
   parameter int unsigned MATCH_CNT     = 4,
   parameter int unsigned SLIP_WAIT     = 3,
   parameter int unsigned ERR_W         = 16
) (
   input  logic                  FAB_CLK,
   input  logic                  RX_SYNC_RST,
   input  logic                  TRAIN_START,
   input  logic [LANE_W-1:0]     RX_DATA,
   input  logic                  RD_VALID_IN,
   input  logic                  PATTERN_MON,
   output logic                  RX_BIT_SLIP,
   output logic                  TRAIN_DONE,
   output logic                  TRAIN_FAIL,
   output logic [SLIP_CNT_W-1:0] SLIP_COUNT,
   output logic [LANE_W-1:0]     RD_DATA,
   output logic                  RD_DATA_VALID,
   output logic [ERR_W-1:0]      ERR_COUNT
);

   localparam int unsigned MATCH_W = (MATCH_CNT > 1) ? $clog2(MATCH_CNT) : 1;
   localparam int unsigned WAIT_W  = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

   rdlvl_state_t          r_state;
   logic                  r_slip;
   logic                  r_done;
   logic                  r_fail;
   logic [SLIP_CNT_W-1:0] r_slip_cnt;
   logic [MATCH_W-1:0]    r_match_cnt;
   logic [WAIT_W-1:0]     r_wait_cnt;
   logic [LANE_W-1:0]     r_rd_data;
   logic                  r_rd_valid;

   rdlvl_state_t          w_state_nxt;
   logic [SLIP_CNT_W-1:0] w_slip_cnt_nxt;
   logic [MATCH_W-1:0]    w_match_cnt_nxt;
   logic [WAIT_W-1:0]     w_wait_cnt_nxt;
   logic [LANE_W-1:0]     w_rd_data_nxt;
   logic                  w_rd_valid_nxt;
   logic                  w_err_clr;
   logic                  w_err_inc;
   logic                  w_match;

   assign w_match = (RX_DATA == TRAIN_PATTERN);

   // State and registered outputs.
   always_ff @(posedge FAB_CLK) begin
      if (RX_SYNC_RST) begin
         r_state     <= ST_IDLE;
         r_slip      <= 1'b0;
         r_done      <= 1'b0;
         r_fail      <= 1'b0;
         r_slip_cnt  <= '0;
         r_match_cnt <= '0;
         r_wait_cnt  <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_slip      <= (w_state_nxt == ST_SLIP);
         r_done      <= (w_state_nxt == ST_LOCKED);
         r_fail      <= (w_state_nxt == ST_FAIL);
         r_slip_cnt  <= w_slip_cnt_nxt;
         r_match_cnt <= w_match_cnt_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_rd_data   <= w_rd_data_nxt;
         r_rd_valid  <= w_rd_valid_nxt;
      end
   end

   // Next-state and datapath decisions.
   always_comb begin
      w_state_nxt     = r_state;
      w_slip_cnt_nxt  = r_slip_cnt;
      w_match_cnt_nxt = r_match_cnt;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_rd_data_nxt   = r_rd_data;
      w_rd_valid_nxt  = 1'b0;
      w_err_clr       = 1'b0;
      w_err_inc       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (TRAIN_START) begin
               w_state_nxt     = ST_CHECK;
               w_slip_cnt_nxt  = '0;
               w_match_cnt_nxt = '0;
               w_err_clr       = 1'b1;
            end
         end

         ST_CHECK: begin
            if (w_match) begin
               if (r_match_cnt == MATCH_W'(MATCH_CNT - 1)) begin
                  w_state_nxt     = ST_LOCKED;
                  w_match_cnt_nxt = '0;
               end else begin
                  w_match_cnt_nxt = r_match_cnt + MATCH_W'(1);
               end
            end else if (r_slip_cnt == SLIP_CNT_W'(NUM_SLIPS - 1)) begin
               // Every other rotation has been tried without a match.
               w_state_nxt = ST_FAIL;
            end else begin
               w_state_nxt     = ST_SLIP;
               w_match_cnt_nxt = '0;
            end
         end

         ST_SLIP: begin
            w_slip_cnt_nxt = r_slip_cnt + SLIP_CNT_W'(1);
            w_wait_cnt_nxt = WAIT_W'(SLIP_WAIT - 1);
            w_state_nxt    = ST_WAIT;
         end

         // Let the IOD slip settle; RX_DATA is not trusted here.
         ST_WAIT: begin
            if (r_wait_cnt == '0) begin
               w_state_nxt = ST_CHECK;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt - WAIT_W'(1);
            end
         end

         ST_LOCKED: begin
            w_rd_data_nxt  = RX_DATA;
            w_rd_valid_nxt = RD_VALID_IN;
            w_err_inc      = PATTERN_MON && !w_match;
            if (TRAIN_START) begin
               w_state_nxt     = ST_CHECK;
               w_slip_cnt_nxt  = '0;
               w_match_cnt_nxt = '0;
               w_err_clr       = 1'b1;
            end
         end

         ST_FAIL: begin
            if (TRAIN_START) begin
               w_state_nxt     = ST_CHECK;
               w_slip_cnt_nxt  = '0;
               w_match_cnt_nxt = '0;
               w_err_clr       = 1'b1;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign RX_BIT_SLIP   = r_slip;
   assign TRAIN_DONE    = r_done;
   assign TRAIN_FAIL    = r_fail;
   assign SLIP_COUNT    = r_slip_cnt;
   assign RD_DATA       = r_rd_data;
   assign RD_DATA_VALID = r_rd_valid;

`ifdef DDR3_RDLVL_ERR_CNT_EN
   ddr3_rdlvl_err_cnt #(
      .W (ERR_W)
   ) u_err_cnt (
      .i_clk (FAB_CLK),
      .i_rst (RX_SYNC_RST),
      .i_clr (w_err_clr),
      .i_inc (w_err_inc),
      .o_cnt (ERR_COUNT)
   );
`else
   // Monitor disabled: sink the unused controls.
   logic w_unused_err;
   assign w_unused_err = ^{PATTERN_MON, w_err_clr, w_err_inc};
   assign ERR_COUNT    = '0;
`endif

endmodule : ddr3_rdlvl_lane_align

// File: tb/tb_ddr3_rdlvl_lane_align.sv
// tb_ddr3_rdlvl_lane_align: directed self-checking bench for ddr3_rdlvl_lane_align.
// Includes a behavioural IOD that rotates the lane word right by one bit per
// slip pulse, taking effect two cycles after the pulse.
module tb_ddr3_rdlvl_lane_align;

   localparam int unsigned TB_ERR_W = 4;
`ifdef DDR3_RDLVL_ERR_CNT_EN
   localparam logic [TB_ERR_W-1:0] EXP_ERR_3   = 4'd3;
   localparam logic [TB_ERR_W-1:0] EXP_ERR_SAT = 4'd15;
`else
   localparam logic [TB_ERR_W-1:0] EXP_ERR_3   = 4'd0;
   localparam logic [TB_ERR_W-1:0] EXP_ERR_SAT = 4'd0;
`endif

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   logic                start = 1'b0;
   logic                rd_valid_in = 1'b0;
   logic                pattern_mon = 1'b0;
   logic [7:0]          rx_data;
   logic                rx_bit_slip;
   logic                train_done;
   logic                train_fail;
   logic [2:0]          slip_count;
   logic [7:0]          rd_data;
   logic                rd_data_valid;
   logic [TB_ERR_W-1:0] err_count;

   // IOD model and stimulus override
   logic [7:0] m_word = 8'h00;
   logic       m_ld = 1'b0;
   logic [7:0] m_ld_val = 8'h00;
   logic       m_d1 = 1'b0;
   logic       m_d2 = 1'b0;
   logic       ovr = 1'b0;
   logic [7:0] ovr_val = 8'h00;

   // Slip monitor
   int cyc = 0;
   int slip_pulses = 0;
   int last_slip = -100;
   int min_gap = 1000;

   int checks = 0;
   int errors = 0;

   assign rx_data = ovr ? ovr_val : m_word;

   always #5 clk = ~clk;

   ddr3_rdlvl_lane_align #(
      .TRAIN_PATTERN (8'hB4),
      .MATCH_CNT     (4),
      .SLIP_WAIT     (3),
      .ERR_W         (TB_ERR_W)
   ) dut (
      .FAB_CLK       (clk),
      .RX_SYNC_RST   (rst),
      .TRAIN_START   (start),
      .RX_DATA       (rx_data),
      .RD_VALID_IN   (rd_valid_in),
      .PATTERN_MON   (pattern_mon),
      .RX_BIT_SLIP   (rx_bit_slip),
      .TRAIN_DONE    (train_done),
      .TRAIN_FAIL    (train_fail),
      .SLIP_COUNT    (slip_count),
      .RD_DATA       (rd_data),
      .RD_DATA_VALID (rd_data_valid),
      .ERR_COUNT     (err_count)
   );

   always @(posedge clk) begin
      m_d1 <= rx_bit_slip;
      m_d2 <= m_d1;
      if (m_ld) m_word <= m_ld_val;
      else if (m_d2) m_word <= {m_word[0], m_word[7:1]};
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_bit_slip) begin
         slip_pulses <= slip_pulses + 1;
         if (cyc - last_slip < min_gap) min_gap <= cyc - last_slip;
         last_slip <= cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_slip_stats();
      slip_pulses = 0;
      min_gap = 1000;
      last_slip = -100;
   endtask

   task automatic load_word(input logic [7:0] w);
      m_ld_val = w;
      m_ld = 1'b1;
      tick();
      m_ld = 1'b0;
   endtask

   // Raise TRAIN_START for one cycle; returns #1 after the sampling edge.
   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (train_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", train_done); end
      checks++; if (train_fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b exp 0", train_fail); end
      checks++; if (rx_bit_slip !== 1'b0) begin errors++; $display("FAIL reset_slip got %b exp 0", rx_bit_slip); end
      checks++; if (slip_count !== 3'd0) begin errors++; $display("FAIL reset_slip_count got %0d exp 0", slip_count); end
      checks++; if (rd_data !== 8'h00 || rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rd got %h/%b exp 00/0", rd_data, rd_data_valid); end
      checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_count); end
   endtask

   task automatic test_aligned();
      load_word(8'hB4);
      clear_slip_stats();
      rd_valid_in = 1'b1;
      pulse_start();
      for (int i = 1; i <= 3; i++) begin
         tick();
         checks++; if (train_done !== 1'b0) begin errors++; $display("FAIL aligned_early_done cyc %0d got %b exp 0", i, train_done); end
      end
      tick();
      checks++; if (train_done !== 1'b1) begin errors++; $display("FAIL aligned_done_lat got %b exp 1", train_done); end
      checks++; if (rd_data_valid !== 1'b0) begin errors++; $display("FAIL prelock_valid got %b exp 0", rd_data_valid); end
      rd_valid_in = 1'b0;
      checks++; if (slip_pulses !== 0 || slip_count !== 3'd0) begin errors++; $display("FAIL aligned_slips got %0d/%0d exp 0/0", slip_pulses, slip_count); end
   endtask

   task automatic test_datapath();
      ovr_val = 8'h3C;
      ovr = 1'b1;
      rd_valid_in = 1'b1;
      tick();
      ovr = 1'b0;
      rd_valid_in = 1'b0;
      checks++; if (rd_data !== 8'h3C || rd_data_valid !== 1'b1) begin errors++; $display("FAIL dp_first got %h/%b exp 3c/1", rd_data, rd_data_valid); end
      tick();
      checks++; if (rd_data !== 8'hB4 || rd_data_valid !== 1'b0) begin errors++; $display("FAIL dp_next got %h/%b exp b4/0", rd_data, rd_data_valid); end
      checks++; if (train_done !== 1'b1) begin errors++; $display("FAIL dp_done got %b exp 1", train_done); end
   endtask

   task automatic test_misaligned();
      load_word(8'hA5);
      clear_slip_stats();
      pulse_start();
      checks++; if (train_done !== 1'b0) begin errors++; $display("FAIL mis_restart_done got %b exp 0", train_done); end
      for (int i = 0; i < 200 && !train_done; i++) tick();
      checks++; if (train_done !== 1'b1) begin errors++; $display("FAIL mis_lock_timeout got %b exp 1", train_done); end
      checks++; if (slip_pulses !== 3 || slip_count !== 3'd3) begin errors++; $display("FAIL mis_slips got %0d/%0d exp 3/3", slip_pulses, slip_count); end
      checks++; if (min_gap < 4) begin errors++; $display("FAIL mis_gap got %0d exp >=4", min_gap); end
   endtask

   task automatic test_unalignable();
      ovr_val = 8'h00;
      ovr = 1'b1;
      for (int run = 0; run < 2; run++) begin
         clear_slip_stats();
         pulse_start();
         checks++; if (train_fail !== 1'b0 || slip_count !== 3'd0) begin errors++; $display("FAIL unal_restart run %0d got %b/%0d exp 0/0", run, train_fail, slip_count); end
         for (int i = 0; i < 200 && !train_fail; i++) tick();
         checks++; if (train_fail !== 1'b1 || train_done !== 1'b0) begin errors++; $display("FAIL unal_state run %0d got fail %b done %b exp 1/0", run, train_fail, train_done); end
         checks++; if (slip_pulses !== 7 || slip_count !== 3'd7) begin errors++; $display("FAIL unal_slips run %0d got %0d/%0d exp 7/7", run, slip_pulses, slip_count); end
         checks++; if (min_gap < 4) begin errors++; $display("FAIL unal_gap run %0d got %0d exp >=4", run, min_gap); end
      end
      ovr = 1'b0;
   endtask

   task automatic test_reset_mid_wait();
      int i;
      load_word(8'hD2);
      clear_slip_stats();
      pulse_start();
      for (i = 0; i < 200 && slip_pulses < 2; i++) tick();
      checks++; if (slip_pulses !== 2) begin errors++; $display("FAIL rmw_two_slips got %0d exp 2", slip_pulses); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({train_done, train_fail, rx_bit_slip, slip_count, rd_data_valid, err_count} !== '0) begin
         errors++; $display("FAIL rmw_outputs got done %b fail %b slip %b cnt %0d val %b err %0d exp all 0",
                            train_done, train_fail, rx_bit_slip, slip_count, rd_data_valid, err_count);
      end
      tick();
      tick();
      clear_slip_stats();
      pulse_start();
      for (i = 0; i < 200 && !train_done; i++) tick();
      checks++; if (train_done !== 1'b1) begin errors++; $display("FAIL rmw_relock got %b exp 1", train_done); end
      checks++; if (slip_pulses !== 0 || slip_count !== 3'd0) begin errors++; $display("FAIL rmw_slips got %0d/%0d exp 0/0", slip_pulses, slip_count); end
   endtask

   task automatic test_err_cnt();
      pattern_mon = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (err_count !== '0) begin errors++; $display("FAIL err_match_noinc got %0d exp 0", err_count); end
      ovr_val = 8'h5A;
      ovr = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      checks++; if (err_count !== EXP_ERR_3) begin errors++; $display("FAIL err_three got %0d exp %0d", err_count, EXP_ERR_3); end
      for (int i = 0; i < 17; i++) tick();
      pattern_mon = 1'b0;
      ovr = 1'b0;
      checks++; if (err_count !== EXP_ERR_SAT) begin errors++; $display("FAIL err_sat got %0d exp %0d", err_count, EXP_ERR_SAT); end
      checks++; if (train_done !== 1'b1) begin errors++; $display("FAIL err_still_locked got %b exp 1", train_done); end
      pulse_start();
      checks++; if (err_count !== '0) begin errors++; $display("FAIL err_clear got %0d exp 0", err_count); end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_datapath();
      test_misaligned();
      test_unalignable();
      test_reset_mid_wait();
      test_err_cnt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ddr3_rdlvl_lane_align
